// File: rtl/video_pkg.sv
// Shared video definitions: mire FSM states, colours and the test-pattern rule.
// Build with MIRE_CHECKER_EN defined for a 16x16 checkerboard instead of the default grid.
package video_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, PAUSE} mire_state_t;

    localparam int          COORD_W = 16;
    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BLACK   = 24'h000000;

    function automatic logic pattern_bit(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y);
`ifdef MIRE_CHECKER_EN
        return x[4] ^ y[4];
`else
        return (x[3:0] == 4'd0) || (y[3:0] == 4'd0);
`endif
    endfunction

    // Bus word for one pixel: {pad, R, G, B}
    function automatic logic [31:0] pixel_word(input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y);
        return {8'h00, (pattern_bit(x, y) ? WHITE : BLACK)};
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic bus bundle between a master, the system arbiter and the SDRAM slave.
interface wshb_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_ms;
    logic [DW-1:0]   dat_sm;
    logic            ack;
    logic            err;
    logic            rty;
    logic [2:0]      cti;
    logic [1:0]      bte;

    modport master (
        output cyc, stb, we, sel, adr, dat_ms, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/pix_counter.sv
// Raster position counter: x/y plus a running byte address (4 bytes per pixel).
// o_nxt_* give the coordinates that will be current after this clock edge.
module pix_counter
    import video_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_adv,
    output logic [COORD_W-1:0] o_nxt_x,
    output logic [COORD_W-1:0] o_nxt_y,
    output logic [31:0]        o_adr,
    output logic               o_wrap
);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [31:0]        r_adr;
    logic               w_eol;
    logic               w_eof;

    assign w_eol  = (r_x == COORD_W'(HDISP - 1));
    assign w_eof  = w_eol && (r_y == COORD_W'(VDISP - 1));
    assign o_wrap = i_adv && w_eof;
    assign o_adr  = r_adr;

    always_comb begin
        o_nxt_x = r_x;
        o_nxt_y = r_y;
        if (i_adv) begin
            if (w_eol) begin
                o_nxt_x = '0;
                o_nxt_y = w_eof ? '0 : r_y + 1'b1;
            end else begin
                o_nxt_x = r_x + 1'b1;
            end
        end
    end

    // Address tracks the raster linearly, so an increment replaces y*HDISP+x
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_adr <= '0;
        end else begin
            r_x <= o_nxt_x;
            r_y <= o_nxt_y;
            if (i_adv)
                r_adr <= w_eof ? 32'd0 : r_adr + 32'd4;
        end
    end

endmodule

// File: rtl/wshb_mire.sv
// Wishbone master painting a test pattern into the SDRAM framebuffer, frame after frame,
// releasing the bus for one cycle after every BURST acked writes. Pattern via MIRE_CHECKER_EN.
module wshb_mire
    import video_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    wshb_if.master wshb_ifm,
    output logic   frame_done
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    mire_state_t        r_state;
    mire_state_t        w_state_nxt;
    logic               w_stb_nxt;
    logic               r_stb;
    logic [31:0]        r_dat;
    logic               r_frame_done;
    logic [BW-1:0]      r_burst_cnt;

    logic               w_ack;
    logic               w_tenure_end;
    logic               w_wrap;
    logic [COORD_W-1:0] w_nx;
    logic [COORD_W-1:0] w_ny;
    logic [31:0]        w_adr;

    // Error or retry leaves the pixel in place so the same write is reissued
    assign w_ack        = r_stb & wshb_ifm.ack & ~wshb_ifm.err & ~wshb_ifm.rty;
    assign w_tenure_end = w_ack && (r_burst_cnt == BW'(BURST - 1));

    pix_counter #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_pix (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_adv   (w_ack),
        .o_nxt_x (w_nx),
        .o_nxt_y (w_ny),
        .o_adr   (w_adr),
        .o_wrap  (w_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_stb_nxt   = 1'b0;
        unique case (r_state)
            IDLE:    w_state_nxt = WRITE;
            WRITE:   if (w_tenure_end) w_state_nxt = PAUSE;
            PAUSE:   w_state_nxt = WRITE;
            default: w_state_nxt = IDLE;
        endcase
        // Strobe is a register fed from the next state; the first WRITE cycle after
        // IDLE raises it, which places the first request on the second edge out of reset.
        w_stb_nxt = (r_state != IDLE) && (w_state_nxt == WRITE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= IDLE;
            r_stb        <= 1'b0;
            r_dat        <= pixel_word('0, '0);
            r_frame_done <= 1'b0;
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_stb        <= w_stb_nxt;
            r_frame_done <= w_wrap;
            if (w_ack)
                r_dat <= pixel_word(w_nx, w_ny);
            if (r_state == PAUSE)
                r_burst_cnt <= '0;
            else if (w_ack)
                r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    assign wshb_ifm.cyc    = r_stb;
    assign wshb_ifm.stb    = r_stb;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.adr    = w_adr;
    assign wshb_ifm.dat_ms = r_dat;
    assign frame_done      = r_frame_done;

endmodule

// File: tb/tb_wshb_mire.sv
// Self-checking bench for wshb_mire on a reduced 80x48 frame; expected bus traffic comes
// from a pixel-index model (adr = 4*n, colour from x = n%H, y = n/H).
module tb_wshb_mire;

    localparam int H     = 80;
    localparam int V     = 48;
    localparam int B     = 64;
    localparam int NPIX  = H * V;
    localparam int FRAME = NPIX + (NPIX + B - 1) / B;

`ifdef MIRE_CHECKER_EN
    localparam logic [31:0] PIX_0_0   = 32'h00000000;
    localparam logic [31:0] PIX_16_0  = 32'h00FFFFFF;
    localparam logic [31:0] PIX_16_16 = 32'h00000000;
`else
    localparam logic [31:0] PIX_0_0   = 32'h00FFFFFF;
    localparam logic [31:0] PIX_16_0  = 32'h00FFFFFF;
    localparam logic [31:0] PIX_16_16 = 32'h00FFFFFF;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic frame_done;
    int   checks  = 0;
    int   errors  = 0;

    wshb_if bus ();

    wshb_mire #(
        .HDISP (H),
        .VDISP (V),
        .BURST (B)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wshb_ifm   (bus),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] exp_dat(input int n);
        int x;
        int y;
        bit w;
        x = n % H;
        y = n / H;
`ifdef MIRE_CHECKER_EN
        w = (((x / 16) + (y / 16)) % 2) == 1;
`else
        w = (x % 16 == 0) || (y % 16 == 0);
`endif
        return w ? 32'h00FFFFFF : 32'h00000000;
    endfunction

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.rty = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.rty = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({bus.cyc, bus.stb, frame_done} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: cyc/stb/frame_done=%b want 000", {bus.cyc, bus.stb, frame_done});
        end
        checks++;
        if (bus.adr !== 32'h0) begin
            errors++; $display("FAIL reset_adr: got %h want 00000000", bus.adr);
        end
        checks++;
        if (bus.dat_ms !== PIX_0_0) begin
            errors++; $display("FAIL reset_dat: got %h want %h", bus.dat_ms, PIX_0_0);
        end
        checks++;
        if ({bus.we, bus.sel, bus.cti, bus.bte} !== {1'b1, 4'hF, 3'b000, 2'b00}) begin
            errors++; $display("FAIL fixed_sigs: got %b want 1111100000", {bus.we, bus.sel, bus.cti, bus.bte});
        end
        sys_rst = 1'b0;
        bus.ack = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.stb !== 1'b0) begin
            errors++; $display("FAIL first_edge_stb: got %b want 0", bus.stb);
        end
        @(negedge sys_clk);
        checks++;
        if ({bus.cyc, bus.stb} !== 2'b11 || bus.adr !== 32'h0) begin
            errors++; $display("FAIL second_edge_stb: cyc/stb=%b adr=%h want 11 / 00000000", {bus.cyc, bus.stb}, bus.adr);
        end
        bus.ack = 1'b0;
    endtask

    // ack asserted on every period-th edge; model follows pixel index n
    task automatic test_stream(input int period);
        int n, pn, fd_edge, tacc, idle, tenures, dupes, uniq, limit;
        bit pstb, pcyc, pack, acked, exp_fd, seen_pause, frame_over;
        logic [31:0] pa;
        bit seen [NPIX];
        n = 0; fd_edge = -1; tacc = 0; idle = 0; tenures = 0; dupes = 0; uniq = 0;
        pstb = 0; pcyc = 0; seen_pause = 0; frame_over = 0; pa = '0;
        foreach (seen[i]) seen[i] = 1'b0;
        limit = period * FRAME + 4 * B;
        apply_reset();
        pack = (period == 1);
        bus.ack = pack;
        for (int e = 1; e <= limit; e++) begin
            @(negedge sys_clk);
            acked = pstb && pack;
            pn = n;
            if (acked) begin
                n = (n + 1) % NPIX;
                tacc++;
                if (!frame_over) begin
                    if (pa[1:0] == 2'b00 && (pa >> 2) < NPIX && !seen[pa >> 2]) begin
                        seen[pa >> 2] = 1'b1; uniq++;
                    end else dupes++;
                end
            end
            exp_fd = acked && (pn == NPIX - 1);
            if (exp_fd) frame_over = 1'b1;
            checks++;
            if (frame_done !== exp_fd) begin
                errors++; $display("FAIL frame_done_p%0d: edge %0d got %b want %b", period, e, frame_done, exp_fd);
            end
            if (frame_done === 1'b1 && fd_edge < 0) fd_edge = e;
            if (bus.stb === 1'b1) begin
                checks++;
                if (bus.adr !== 32'(4 * n) || bus.dat_ms !== exp_dat(n) || bus.cyc !== 1'b1) begin
                    errors++; $display("FAIL pixel_p%0d: n=%0d adr=%h dat=%h cyc=%b want %h %h 1",
                                       period, n, bus.adr, bus.dat_ms, bus.cyc, 32'(4 * n), exp_dat(n));
                end
                if (period == 1 && fd_edge < 0) begin
                    if (n == 0) begin
                        checks++;
                        if (bus.dat_ms !== PIX_0_0) begin
                            errors++; $display("FAIL pix_0_0: got %h want %h", bus.dat_ms, PIX_0_0);
                        end
                    end
                    if (n == 5) begin
                        checks++;
                        if (bus.adr !== 32'h14) begin
                            errors++; $display("FAIL write5_adr: got %h want 00000014", bus.adr);
                        end
                    end
                    if (n == 16) begin
                        checks++;
                        if (bus.adr !== 32'h40 || bus.dat_ms !== PIX_16_0) begin
                            errors++; $display("FAIL pix_16_0: adr=%h dat=%h want 00000040 %h", bus.adr, bus.dat_ms, PIX_16_0);
                        end
                    end
                    if (n == 16 * H + 16) begin
                        checks++;
                        if (bus.dat_ms !== PIX_16_16) begin
                            errors++; $display("FAIL pix_16_16: got %h want %h", bus.dat_ms, PIX_16_16);
                        end
                    end
                end
            end
            if (bus.cyc === 1'b0 && pcyc) begin
                checks++;
                if (tacc != B) begin
                    errors++; $display("FAIL tenure_len_p%0d: got %0d acked writes want %0d", period, tacc, B);
                end
                tacc = 0; idle = 0; seen_pause = 1'b1; tenures++;
            end
            if (bus.cyc === 1'b0) idle++;
            if (bus.cyc === 1'b1 && !pcyc && seen_pause) begin
                checks++;
                if (idle != 1) begin
                    errors++; $display("FAIL pause_len_p%0d: got %0d idle cycles want 1", period, idle);
                end
                if (tenures == 1) begin
                    checks++;
                    if (bus.adr !== 32'h100) begin
                        errors++; $display("FAIL reassert_adr: got %h want 00000100", bus.adr);
                    end
                end
            end
            pstb = (bus.stb === 1'b1);
            pcyc = (bus.cyc === 1'b1);
            pa   = bus.adr;
            pack = (period == 1) ? 1'b1 : (((e + 1) % period) == 0);
            bus.ack = pack;
            if (fd_edge > 0 && e > fd_edge + 2 * B) break;
        end
        bus.ack = 1'b0;
        checks++;
        if (fd_edge < 0) begin
            errors++; $display("FAIL frame_done_seen_p%0d: no pulse within %0d cycles", period, limit);
        end
        if (period == 1) begin
            checks++;
            if (fd_edge != FRAME + 1) begin
                errors++; $display("FAIL frame_period: frame_done at edge %0d want %0d", fd_edge, FRAME + 1);
            end
        end
        checks++;
        if (dupes != 0 || uniq != NPIX) begin
            errors++; $display("FAIL write_once_p%0d: %0d distinct, %0d repeated want %0d, 0", period, uniq, dupes, NPIX);
        end
    endtask

    task automatic test_err_retry();
        int k;
        apply_reset();
        bus.ack = 1'b1;
        k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (!(bus.stb === 1'b1 && bus.adr === 32'h80) && k < 200);
        checks++;
        if (bus.adr !== 32'h80) begin
            errors++; $display("FAIL err_reach: adr=%h want 00000080 within 200 cycles", bus.adr);
        end
        bus.ack = 1'b0; bus.err = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.adr !== 32'h80 || bus.stb !== 1'b1 || bus.dat_ms !== exp_dat(32)) begin
            errors++; $display("FAIL err_hold: adr=%h stb=%b dat=%h want 00000080 1 %h", bus.adr, bus.stb, bus.dat_ms, exp_dat(32));
        end
        bus.err = 1'b0; bus.rty = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.adr !== 32'h80 || bus.stb !== 1'b1) begin
            errors++; $display("FAIL rty_hold: adr=%h stb=%b want 00000080 1", bus.adr, bus.stb);
        end
        bus.rty = 1'b0; bus.ack = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (bus.adr !== 32'h84 || bus.dat_ms !== exp_dat(33)) begin
            errors++; $display("FAIL err_advance: adr=%h dat=%h want 00000084 %h", bus.adr, bus.dat_ms, exp_dat(33));
        end
        bus.ack = 1'b0;
    endtask

    task automatic test_rst_mid();
        int k;
        apply_reset();
        bus.ack = 1'b1;
        k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (!(bus.stb === 1'b1 && bus.adr === 32'h1000) && k < 2000);
        checks++;
        if (bus.adr !== 32'h1000 || bus.stb !== 1'b1) begin
            errors++; $display("FAIL rst_reach: adr=%h stb=%b want 00001000 1", bus.adr, bus.stb);
        end
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({bus.cyc, bus.stb} !== 2'b00 || bus.adr !== 32'h0) begin
            errors++; $display("FAIL rst_async: cyc/stb=%b adr=%h want 00 00000000", {bus.cyc, bus.stb}, bus.adr);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (bus.stb !== 1'b1 || bus.adr !== 32'h0 || bus.dat_ms !== exp_dat(0)) begin
            errors++; $display("FAIL rst_restart: stb=%b adr=%h dat=%h want 1 00000000 %h", bus.stb, bus.adr, bus.dat_ms, exp_dat(0));
        end
        @(negedge sys_clk);
        checks++;
        if (bus.adr !== 32'h4 || bus.dat_ms !== exp_dat(1)) begin
            errors++; $display("FAIL rst_second: adr=%h dat=%h want 00000004 %h", bus.adr, bus.dat_ms, exp_dat(1));
        end
        bus.ack = 1'b0;
    endtask

    initial begin
        bus.ack    = 1'b0;
        bus.err    = 1'b0;
        bus.rty    = 1'b0;
        bus.dat_sm = '0;
        test_reset();
        test_stream(1);
        test_stream(3);
        test_err_retry();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
